// File: rtl/store_monitor.sv
// Store-stream checker for the multi-cycle RISC-V core: classifies every data
// store, latches a sticky pass/fail verdict with cause, and keeps statistics.
module store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd108,
  parameter logic [31:0] PASS_DATA      = 32'h3FFF_FFFF,
  parameter logic [31:0] ALLOW_ADDR0    = 32'd100,
  parameter logic [31:0] ALLOW_ADDR1    = 32'd104,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [15:0] store_count,
  output logic [31:0] cycle_count,
  output logic [31:0] last_addr,
  output logic [31:0] last_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ADDR    = 2'd1,
    FC_DATA    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  fail_code_t  r_fail_code;
  logic [15:0] r_store_count;
  logic [31:0] r_cycle_count;
  logic [31:0] r_last_addr;
  logic [31:0] r_last_data;

  state_t      w_state_next;
  fail_code_t  w_fail_code_next;
  logic [15:0] w_store_count_next;
  logic [31:0] w_cycle_count_next;
  logic [31:0] w_last_addr_next;
  logic [31:0] w_last_data_next;

  logic        w_hit_pass_addr;
  logic        w_hit_pass_data;
  logic        w_hit_scratch;
  logic        w_timed_out;
  logic [15:0] w_store_count_inc;
  logic [31:0] w_cycle_count_inc;

  assign w_hit_pass_addr = (DataAdr == PASS_ADDR);
  assign w_hit_pass_data = (WriteData == PASS_DATA);
  assign w_hit_scratch   = (DataAdr == ALLOW_ADDR0) || (DataAdr == ALLOW_ADDR1);
  // A legal store on the timeout edge pushes the count past the limit, hence >=.
  assign w_timed_out     = (r_cycle_count >= TIMEOUT_LAST);

  assign w_store_count_inc = (r_store_count == 16'hFFFF) ? r_store_count
                                                         : r_store_count + 16'd1;
  assign w_cycle_count_inc = (r_cycle_count == 32'hFFFF_FFFF) ? r_cycle_count
                                                              : r_cycle_count + 32'd1;

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_next       = r_state;
    w_fail_code_next   = r_fail_code;
    w_store_count_next = r_store_count;
    w_cycle_count_next = r_cycle_count;
    w_last_addr_next   = r_last_addr;
    w_last_data_next   = r_last_data;

    unique case (r_state)
      S_IDLE: w_state_next = S_RUN;

      S_RUN: begin
        if (MemWrite) begin
          w_last_addr_next   = DataAdr;
          w_last_data_next   = WriteData;
          w_cycle_count_next = w_cycle_count_inc;
          if (w_hit_pass_addr && w_hit_pass_data) begin
            w_state_next = S_PASS;
          end else if (w_hit_pass_addr) begin
            w_state_next     = S_FAIL;
            w_fail_code_next = FC_DATA;
          end else if (w_hit_scratch) begin
            w_store_count_next = w_store_count_inc;
          end else begin
            w_state_next     = S_FAIL;
            w_fail_code_next = FC_ADDR;
          end
        end else if (w_timed_out) begin
          w_state_next     = S_FAIL;
          w_fail_code_next = FC_TIMEOUT;
        end else begin
          w_cycle_count_next = w_cycle_count_inc;
        end
      end

      // Verdict states absorb everything until reset.
      S_PASS, S_FAIL: ;

      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_fail_code   <= FC_NONE;
      r_store_count <= '0;
      r_cycle_count <= '0;
      r_last_addr   <= '0;
      r_last_data   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_fail_code   <= w_fail_code_next;
      r_store_count <= w_store_count_next;
      r_cycle_count <= w_cycle_count_next;
      r_last_addr   <= w_last_addr_next;
      r_last_data   <= w_last_data_next;
    end
  end

  assign done        = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass        = (r_state == S_PASS);
  assign fail_code   = r_fail_code;
  assign store_count = r_store_count;
  assign cycle_count = r_cycle_count;
  assign last_addr   = r_last_addr;
  assign last_data   = r_last_data;

endmodule

// File: tb/tb_store_monitor.sv
// Randomised scoreboard bench for store_monitor: a per-edge reference model
// queues expected outputs, a monitor pops and compares on each falling edge.
module tb_store_monitor;

  localparam logic [31:0] PASS_ADDR   = 32'd108;
  localparam logic [31:0] PASS_DATA   = 32'h3FFF_FFFF;
  localparam logic [31:0] ALLOW_ADDR0 = 32'd100;
  localparam logic [31:0] ALLOW_ADDR1 = 32'd104;
  localparam int unsigned TIMEOUT     = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [15:0] store_count;
  logic [31:0] cycle_count;
  logic [31:0] last_addr;
  logic [31:0] last_data;

  store_monitor #(
    .PASS_ADDR      (PASS_ADDR),
    .PASS_DATA      (PASS_DATA),
    .ALLOW_ADDR0    (ALLOW_ADDR0),
    .ALLOW_ADDR1    (ALLOW_ADDR1),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .store_count (store_count),
    .cycle_count (cycle_count),
    .last_addr   (last_addr),
    .last_data   (last_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic [1:0]  code;
    logic [15:0] stores;
    logic [31:0] cycles;
    logic [31:0] la;
    logic [31:0] ld;
  } snap_t;

  snap_t q_exp[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model: "started" means the first post-reset edge has passed,
  // "verdict" is 0 none / 1 pass / 2 fail.
  bit          m_started;
  int          m_verdict;
  int          m_code;
  longint      m_stores;
  longint      m_cycles;
  logic [31:0] m_la;
  logic [31:0] m_ld;

  task automatic model_edge(input bit rst, input bit mw,
                            input logic [31:0] a, input logic [31:0] d);
    if (rst) begin
      m_started = 0; m_verdict = 0; m_code = 0;
      m_stores = 0; m_cycles = 0; m_la = '0; m_ld = '0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_verdict == 0) begin
      if (mw) begin
        m_la = a;
        m_ld = d;
        m_cycles = (m_cycles + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cycles + 1;
        if (a == PASS_ADDR) begin
          if (d == PASS_DATA) m_verdict = 1;
          else begin m_verdict = 2; m_code = 2; end
        end else if (a == ALLOW_ADDR0 || a == ALLOW_ADDR1) begin
          m_stores = (m_stores + 1 > 65535) ? 65535 : m_stores + 1;
        end else begin
          m_verdict = 2; m_code = 1;
        end
      end else if (m_cycles >= TIMEOUT - 1) begin
        m_verdict = 2; m_code = 3;
      end else begin
        m_cycles = m_cycles + 1;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit mw,
                       input logic [31:0] a, input logic [31:0] d);
    snap_t s;
    @(negedge clk);
    reset = rst; MemWrite = mw; DataAdr = a; WriteData = d;
    @(posedge clk);
    model_edge(rst, mw, a, d);
    s.done   = (m_verdict != 0);
    s.pass   = (m_verdict == 1);
    s.code   = 2'(m_code);
    s.stores = 16'(m_stores);
    s.cycles = 32'(m_cycles);
    s.la     = m_la;
    s.ld     = m_ld;
    q_exp.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so each falling edge shows the result
  // of the preceding rising edge.
  always @(negedge clk) begin
    snap_t act;
    snap_t exp;
    if (q_exp.size() > 0) begin
      exp = q_exp.pop_front();
      act = '{done, pass, fail_code, store_count, cycle_count, last_addr, last_data};
      n_cmp++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL scoreboard @%0t: got done=%b pass=%b code=%0d sc=%0d cc=%0d la=%h ld=%h expected done=%b pass=%b code=%0d sc=%0d cc=%0d la=%h ld=%h",
                 $time, act.done, act.pass, act.code, act.stores, act.cycles, act.la, act.ld,
                 exp.done, exp.pass, exp.code, exp.stores, exp.cycles, exp.la, exp.ld);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          len;

    // Shift program; the store on the IDLE-exit edge must be ignored.
    do_reset(2);
    #1 check("reset_done", 32'(done), 32'd0);
    check("reset_cycles", cycle_count, 32'd0);
    drive(1'b0, 1'b1, 32'd200, 32'd5);
    drive(1'b0, 1'b1, 32'd100, 32'h1234_5678);
    drive(1'b0, 1'b1, 32'd104, 32'h9ABC_DEF0);
    drive(1'b0, 1'b1, PASS_ADDR, PASS_DATA);
    #1 check("shift_done", 32'(done), 32'd1);
    check("shift_pass", 32'(pass), 32'd1);
    check("shift_code", 32'(fail_code), 32'd0);
    check("shift_stores", 32'(store_count), 32'd2);
    check("shift_last_addr", last_addr, 32'd108);
    drive(1'b0, 1'b1, 32'd300, 32'd1);

    // Illegal address, then a terminal store that must be ignored.
    do_reset(1); idle(1);
    drive(1'b0, 1'b1, 32'd200, 32'd5);
    #1 check("illegal_code", 32'(fail_code), 32'd1);
    check("illegal_pass", 32'(pass), 32'd0);
    check("illegal_last_addr", last_addr, 32'd200);
    drive(1'b0, 1'b1, PASS_ADDR, PASS_DATA);
    #1 check("absorb_pass", 32'(pass), 32'd0);
    check("absorb_last_addr", last_addr, 32'd200);

    // Wrong terminal data.
    do_reset(1); idle(1);
    drive(1'b0, 1'b1, PASS_ADDR, 32'h7FFF_FFFF);
    #1 check("wrongdata_code", 32'(fail_code), 32'd2);
    check("wrongdata_last_data", last_data, 32'h7FFF_FFFF);

    // Timeout exactly TIMEOUT edges after RUN entry.
    do_reset(1); idle(1);
    idle(TIMEOUT - 1);
    #1 check("timeout_early", 32'(done), 32'd0);
    idle(1);
    #1 check("timeout_done", 32'(done), 32'd1);
    check("timeout_code", 32'(fail_code), 32'd3);
    check("timeout_cycles", cycle_count, 32'(TIMEOUT - 1));

    // Store on the timeout edge wins; next idle edge times out.
    do_reset(1); idle(1);
    idle(TIMEOUT - 1);
    drive(1'b0, 1'b1, 32'd100, 32'd0);
    #1 check("collide_done", 32'(done), 32'd0);
    check("collide_stores", 32'(store_count), 32'd1);
    idle(1);
    #1 check("collide_code", 32'(fail_code), 32'd3);

    // Reset mid-run clears counters; reset in FAIL clears done at once.
    do_reset(1); idle(1);
    drive(1'b0, 1'b1, 32'd100, 32'd1);
    drive(1'b0, 1'b1, 32'd104, 32'd2);
    drive(1'b0, 1'b1, 32'd100, 32'd3);
    do_reset(1); idle(1);
    drive(1'b0, 1'b1, PASS_ADDR, PASS_DATA);
    #1 check("midrst_stores", 32'(store_count), 32'd0);
    check("midrst_pass", 32'(pass), 32'd1);
    do_reset(1); idle(1);
    drive(1'b0, 1'b1, 32'd300, 32'd1);
    do_reset(1);
    #1 check("failrst_done", 32'(done), 32'd0);

    // Random runs against the model.
    for (int r = 0; r < 40; r++) begin
      do_reset($urandom_range(1, 2));
      len = $urandom_range(3, 30);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 49) == 0) begin
          do_reset(1);
        end else if ($urandom_range(0, 9) < 4) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3: a = ALLOW_ADDR0;
            4, 5, 6:    a = ALLOW_ADDR1;
            7, 8:       a = PASS_ADDR;
            default:    a = $urandom;
          endcase
          d = ($urandom_range(0, 1) == 1) ? PASS_DATA : $urandom;
          drive(1'b0, 1'b1, a, d);
        end else begin
          idle(1);
        end
      end
    end

    for (int i = 0; i < 4 && q_exp.size() > 0; i++) @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
# store_monitor

Synthesizable store-stream checker that sits directly downstream of the multi-cycle RISC-V `top` and consumes its `MemWrite`, `DataAdr` and `WriteData` outputs. It classifies every data-memory store as allowed scratch traffic, the terminal "success" store, or an illegal store. It latches a sticky pass/fail verdict with a cause code and keeps store and cycle statistics. It replaces hand-written per-program negedge checkers, so the same pass/fail logic runs in simulation and on an FPGA board, where `done` and `pass` drive LEDs.

## Interface
Parameters:
- `PASS_ADDR`, 108: address of the terminal store.
- `PASS_DATA`, 32'h3FFFFFFF: data required at `PASS_ADDR`.
- `ALLOW_ADDR0`, 100: first permitted scratch address.
- `ALLOW_ADDR1`, 104: second permitted scratch address.
- `TIMEOUT_CYCLES`, 4096: run cycles allowed before the block declares a timeout; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MemWrite` in 1: store strobe from `top`.
- `DataAdr` in 32: store address from `top`.
- `WriteData` in 32: store data from `top`.
- `done` out 1: verdict reached; sticky.
- `pass` out 1: verdict is success; valid only when `done`=1.
- `fail_code` out 2: 0 none, 1 illegal address, 2 wrong data at `PASS_ADDR`, 3 timeout.
- `store_count` out 16: legal scratch stores seen; saturates at 16'hFFFF.
- `cycle_count` out 32: cycles spent in RUN; saturates at 32'hFFFFFFFF.
- `last_addr` out 32: address of the most recent evaluated store.
- `last_data` out 32: data of the most recent evaluated store.

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: entered whenever `reset`=1 at a rising edge. All outputs are 0. The next edge with `reset`=0 moves to RUN.
- RUN: evaluates stores in this priority order when `MemWrite`=1:
  - `DataAdr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  - `DataAdr`==`PASS_ADDR` with any other data → FAIL, code 2.
  - `DataAdr` is `ALLOW_ADDR0` or `ALLOW_ADDR1` → stay in RUN, `store_count`+1.
  - Any other address → FAIL, code 1.
- Every evaluated store in RUN updates `last_addr` and `last_data`, including the terminal store.
- RUN with `MemWrite`=0: `cycle_count`+1. When `cycle_count` reaches `TIMEOUT_CYCLES`-1 with no store that edge → FAIL, code 3.
- `cycle_count` increments on every RUN cycle, store or not.
- PASS and FAIL are absorbing until reset. In these states:
  - `done`=1; `pass` is 1 in PASS, 0 in FAIL.
  - `MemWrite` is ignored.
  - All counters and `last_*` registers are frozen.
- `MemWrite` with X/Z values is not handled; the producer guarantees known levels after reset.
- All comparisons are full 32-bit equality. No masking and no alignment checks.

## Timing
- Inputs are sampled at rising edge k. The resulting state and outputs are visible after edge k, one cycle after the store is presented.
- All outputs are registered; there are no combinational paths from input to output.
- Reset is synchronous:
  - `reset`=1 at edge k clears everything at edge k.
  - RUN is entered at the first edge where `reset`=0.
  - A store presented on that first edge is not evaluated, because the block is still leaving IDLE.
- Reset mid-RUN, or in PASS/FAIL, clears the verdict and the counters. A new run starts after deassertion.
- Timeout and store on the same edge: the store wins. This applies even if the store is legal, in which case the block stays in RUN. Timeout is then re-evaluated on the next store-free edge, where `cycle_count` ≥ `TIMEOUT_CYCLES`-1 also fails with code 3.
- Back-to-back stores on consecutive edges are each evaluated. There is no minimum spacing.
- Saturation: a counter at its maximum holds its value and does not wrap.

## Test plan
- Shift program run: hold `reset` high for 2 edges, then send stores (100, x), (104, y), (108, 32'h3FFFFFFF) → `done`=1, `pass`=1, `fail_code`=0, `store_count`=2, `last_addr`=108, one cycle after the final store.
- Illegal address: after reset, store (200, 5) → `done`=1, `pass`=0, `fail_code`=1, `last_addr`=200. A further store (108, 32'h3FFFFFFF) leaves the outputs unchanged.
- Wrong terminal data: store (108, 32'h7FFFFFFF) → `fail_code`=2, `pass`=0, `last_data`=32'h7FFFFFFF.
- Timeout: with `TIMEOUT_CYCLES`=16 and no stores → `done` rises exactly 16 edges after RUN entry, `fail_code`=3, `cycle_count`=15.
- Timeout collision: with `TIMEOUT_CYCLES`=16, store (100, 0) on the 16th RUN edge → stays in RUN with `store_count`=1. The next idle edge → `fail_code`=3.
- Reset mid-run: three scratch stores, then `reset` for 1 edge, then (108, 32'h3FFFFFFF) → `store_count`=0 and `pass`=1. Asserting reset while in FAIL clears `done` on the same edge.
